// File: rtl/decoder_pkg.sv
// Shared definitions for the pulsed 2-to-4 decoder: FSM encoding, code
// constants, timer width and the code-to-line helper.
package decoder_pkg;

    localparam int TMR_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic [1:0] CODE_D0 = 2'b00;
    localparam logic [1:0] CODE_D1 = 2'b01;
    localparam logic [1:0] CODE_D2 = 2'b10;
    localparam logic [1:0] CODE_D3 = 2'b11;

    // Map a 2-bit code to its one-hot line vector {d3,d2,d1,d0}.
    function automatic logic [3:0] onehot4(input logic [1:0] code);
        logic [3:0] v;
        v = 4'b0000;
        unique case (code)
            CODE_D0: v = 4'b0001;
            CODE_D1: v = 4'b0010;
            CODE_D2: v = 4'b0100;
            CODE_D3: v = 4'b1000;
            default: v = 4'b0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise step up unless already at full scale.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/decoder_2to4_pulse.sv
// Sequential 2-to-4 decoder: accepts a code over valid/ready, drives the
// matching line for PULSE_LEN cycles, then holds one idle gap cycle.
// Per-line saturating accept counters support bring-up.
module decoder_2to4_pulse
    import decoder_pkg::*;
#(
    parameter int PULSE_LEN = 3,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clr_cnt,
    output logic             d0,
    output logic             d1,
    output logic             d2,
    output logic             d3,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(PULSE_LEN - 1);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q,   tmr_d;
    logic [1:0]       code_q,  code_d;
    logic [3:0]       line_q,  line_d;

    logic             accept;
    logic [3:0]       inc;
    logic [CNT_W-1:0] cnt [4];

    assign accept = in_valid && in_ready;

    // State register: FSM state, pulse timer, latched code and registered lines.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge here, so it belongs inside the clocked branch only.
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            code_q  <= '0;
            line_q  <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
            state_q <= state_d;
            tmr_q   <= tmr_d;
            code_q  <= code_d;
            line_q  <= line_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in PULSE, one cycle of GAP.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        code_d  = code_q;
        line_d  = line_q;
        unique case (state_q)
            IDLE: begin
                line_d = '0;
                if (accept) begin
                    state_d = PULSE;
                    tmr_d   = TMR_LOAD;
                    code_d  = {a, b};
                    line_d  = onehot4({a, b});
                end
            end
            PULSE: begin
                if (tmr_q == '0) begin
                    state_d = GAP;
                    line_d  = '0;
                end else begin
                    tmr_d  = tmr_q - 1'b1;
                    line_d = onehot4(code_q);
                end
            end
            GAP: begin
                state_d = IDLE;
                line_d  = '0;
            end
            default: begin
                state_d = IDLE;
                line_d  = '0;
            end
        endcase
    end

    // Outputs: handshake and status from registered state, lines from their register.
    always_comb begin
        in_ready = (state_q == IDLE) && !rst;
        busy     = (state_q != IDLE);
        d0       = line_q[0];
        d1       = line_q[1];
        d2       = line_q[2];
        d3       = line_q[3];
    end

    // One saturating accept counter per decoded line.
    for (genvar i = 0; i < 4; i++) begin : g_cnt
        assign inc[i] = accept && ({a, b} == 2'(i));

        sat_counter #(
            .W(CNT_W)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (clr_cnt),
            .inc (inc[i]),
            .q   (cnt[i])
        );
    end

    assign cnt0 = cnt[0];
    assign cnt1 = cnt[1];
    assign cnt2 = cnt[2];
    assign cnt3 = cnt[3];

endmodule
